dmem_mmio: RTL

//   Data-memory stage of the single-cycle core. Consumes the datapath's aluout (address),

---
 rtl/dmem_mmio.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM with memory-mapped GPIO and a down-counting timer.
// Reads are combinational. All register state updates on the rising clock edge.
module dmem_mmio #(
   parameter int DEPTH_WORDS = 64,
   parameter int ADDR_BITS   = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   input  logic [7:0]  gpio_in,
   output logic [7:0]  gpio_out,
   output logic        timer_irq
);

   // MMIO register word offsets (byte offset >> 2)
   localparam logic [13:0] W_GPIO_OUT = 14'h0000;
   localparam logic [13:0] W_GPIO_IN  = 14'h0001;
   localparam logic [13:0] W_CTRL     = 14'h0002;
   localparam logic [13:0] W_LOAD     = 14'h0003;
   localparam logic [13:0] W_COUNT    = 14'h0004;
   localparam logic [13:0] W_STATUS   = 14'h0005;

   logic [31:0]          ram [DEPTH_WORDS];
   logic [ADDR_BITS-1:0] idx;
   logic [13:0]          word;
   logic                 mmio;
   logic                 wr_mmio;
   logic                 wr_ram;

   logic [7:0]  gpio_r;
   logic [7:0]  sync1;
   logic [7:0]  sync2;
   logic        en;
   logic        irq_en;
   logic        auto_rl;
   logic [31:0] load;
   logic [31:0] count;
   logic        exp_f;

   logic        wr_gpio;
   logic        wr_ctrl;
   logic        wr_load;
   logic        wr_status;
   logic        expire;
   logic [31:0] mmio_rd;
   logic [1:0]  unused_lsb;

   // Byte-lane bits play no part in word accesses.
   assign unused_lsb = a[1:0];

   assign mmio    = (a[31:16] == 16'hFFFF);
   assign word    = a[15:2];
   assign idx     = a[ADDR_BITS+1:2];
   assign wr_mmio = we & mmio & ~reset;
   assign wr_ram  = we & ~mmio & ~reset;

   // Per-register write strobes from the MMIO word offset
   always_comb begin
      wr_gpio   = 1'b0;
      wr_ctrl   = 1'b0;
      wr_load   = 1'b0;
      wr_status = 1'b0;
      if (wr_mmio) begin
         unique case (1'b1)
            (word == W_GPIO_OUT): wr_gpio   = 1'b1;
            (word == W_CTRL):     wr_ctrl   = 1'b1;
            (word == W_LOAD):     wr_load   = 1'b1;
            (word == W_STATUS):   wr_status = 1'b1;
            default:              ;
         endcase
      end
   end

   // A LOAD write pre-empts both decrement and expiry in the same cycle.
   assign expire = en & ~wr_load & (count == 32'h0);

   // RAM write port; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_ram) begin
         ram[idx] <= wd;
      end
   end

   // GPIO output register and two-flop input synchroniser
   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_r <= 8'h00;
         sync1  <= 8'h00;
         sync2  <= 8'h00;
      end else begin
         sync1 <= gpio_in;
         sync2 <= sync1;
         if (wr_gpio) begin
            gpio_r <= wd[7:0];
         end
      end
   end

   // Timer control; a CTRL write overrides the expiry clearing EN
   always_ff @(posedge clk) begin
      if (reset) begin
         en      <= 1'b0;
         irq_en  <= 1'b0;
         auto_rl <= 1'b0;
         load    <= 32'h0;
      end else begin
         if (wr_load) begin
            load <= wd;
         end
         if (wr_ctrl) begin
            en      <= wd[0];
            irq_en  <= wd[1];
            auto_rl <= wd[2];
         end else if (expire && !auto_rl) begin
            en <= 1'b0;
         end
      end
   end

   // Timer counter: load, decrement, or reload on expiry
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 32'h0;
      end else if (wr_load) begin
         count <= wd;
      end else if (en && count != 32'h0) begin
         count <= count - 32'h1;
      end else if (expire && auto_rl) begin
         count <= load;
      end
   end

   // Expiry flag; setting beats a simultaneous write-1-to-clear
   always_ff @(posedge clk) begin
      if (reset) begin
         exp_f <= 1'b0;
      end else if (expire) begin
         exp_f <= 1'b1;
      end else if (wr_status && wd[0]) begin
         exp_f <= 1'b0;
      end
   end

   // MMIO read mux; unmapped offsets read as zero
   always_comb begin
      mmio_rd = 32'h0;
      unique case (1'b1)
         (word == W_GPIO_OUT): mmio_rd = {24'h0, gpio_r};
         (word == W_GPIO_IN):  mmio_rd = {24'h0, sync2};
         (word == W_CTRL):     mmio_rd = {29'h0, auto_rl, irq_en, en};
         (word == W_LOAD):     mmio_rd = load;
         (word == W_COUNT):    mmio_rd = count;
         (word == W_STATUS):   mmio_rd = {31'h0, exp_f};
         default:              mmio_rd = 32'h0;
      endcase
   end

   assign rd        = mmio ? mmio_rd : ram[idx];
   assign gpio_out  = gpio_r;
   assign timer_irq = exp_f & irq_en;

endmodule
